data_memory_param: RTL and testbench

//   Parametrised successor to the line-based data memory behind the D-cache.

---
 rtl/data_memory_param.sv | 144 ++++++++++++++
 tb/tb_data_memory_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_param.sv
// Line-wide data memory behind the D-cache: whole-line reads/writes, optional byte-enable merge.
// Latency: accepted request acks LATENCY+1 cycles later; back-to-back requests every LATENCY+1 cycles.
// Backpressure: requester holds enable_i until ack_o; busy_o high while a request is in flight.
module data_memory_param #(
  parameter int LINE_BITS = 256,
  parameter int DEPTH     = 512,
  parameter int LATENCY   = 10,
  parameter int BE_EN     = 0,
  parameter int ADDR_BITS = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [ADDR_BITS-1:0]   addr_i,
  input  logic [LINE_BITS-1:0]   data_i,
  input  logic [LINE_BITS/8-1:0] be_i,
  input  logic                   enable_i,
  input  logic                   write_i,
  output logic                   ack_o,
  output logic [LINE_BITS-1:0]   data_o,
  output logic                   err_o,
  output logic                   busy_o,
  output logic [31:0]            rd_count_o,
  output logic [31:0]            wr_count_o
);

  localparam int BYTES    = LINE_BITS / 8;
  localparam int OFF_BITS = $clog2(BYTES);
  localparam int IDX_BITS = $clog2(DEPTH);
  localparam int LN_BITS  = ADDR_BITS - OFF_BITS;
  localparam logic [7:0] LAST_CNT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t               state, state_nxt;
  logic [LN_BITS-1:0]   line_q;
  logic [LINE_BITS-1:0] data_q;
  logic [BYTES-1:0]     be_q;
  logic                 write_q;
  logic                 err_q;
  logic [7:0]           cnt;
  logic                 accept, access, oor;
  logic [IDX_BITS-1:0]  idx;
  logic [LINE_BITS-1:0] mask, wr_line;
  logic [LINE_BITS-1:0] mem [DEPTH];

  // Byte offset within a line never selects anything: accesses are line-aligned.
  logic unused_offset;
  assign unused_offset = ^addr_i[OFF_BITS-1:0];

  assign idx = line_q[IDX_BITS-1:0];

  generate
    if (LN_BITS > IDX_BITS) begin : g_range
      assign oor = |line_q[LN_BITS-1:IDX_BITS];
    end else begin : g_norange
      assign oor = 1'b0;
    end
  endgenerate

  // The ack cycle doubles as an acceptance slot so a held enable_i streams at LATENCY+1.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (enable_i) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == LAST_CNT) begin
          access    = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (enable_i) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mask = '0;
    for (int k = 0; k < BYTES; k++) begin
      mask[8*k +: 8] = {8{(BE_EN == 0) || be_q[k]}};
    end
    wr_line = (mem[idx] & ~mask) | (data_q & mask);
  end

  assign ack_o  = (state == ACK);
  assign err_o  = (state == ACK) && err_q;
  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      line_q     <= '0;
      data_q     <= '0;
      be_q       <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt        <= '0;
      data_o     <= '0;
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        line_q  <= addr_i[ADDR_BITS-1:OFF_BITS];
        data_q  <= data_i;
        be_q    <= be_i;
        write_q <= write_i;
        cnt     <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 8'd1;
      end
      if (access) begin
        err_q <= oor;
        if (write_q) begin
          wr_count_o <= wr_count_o + 32'd1;
        end else begin
          rd_count_o <= rd_count_o + 32'd1;
          data_o     <= oor ? '0 : mem[idx];
        end
      end
    end
  end

  // Array is deliberately outside reset so its contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (access && write_q && !oor) begin
      mem[idx] <= wr_line;
    end
  end

endmodule

// File: tb/tb_data_memory_param.sv
// Directed bench for data_memory_param: port 0 is LATENCY=10 full-line, port 1 is LATENCY=1 with byte enables.
module tb_data_memory_param;

  typedef struct {
    bit          wr;
    logic [31:0]  addr;
    logic [255:0] dat;
    logic [31:0]  be;
  } op_t;

  typedef struct {
    logic [255:0] dat;
    logic         err;
    logic [31:0]  rdc;
    logic [31:0]  wrc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0]  addr [2];
  logic [255:0] din  [2];
  logic [31:0]  be   [2];
  logic         en   [2];
  logic         wr   [2];
  logic         ack  [2];
  logic         err  [2];
  logic         busy [2];
  logic [255:0] dout [2];
  logic [31:0]  rdc  [2];
  logic [31:0]  wrc  [2];

  op_t  ops [$];
  exp_t sb  [$];
  logic [255:0] mdl [2][512];
  logic [255:0] last_rd [2];
  int unsigned  exp_rd [2];
  int unsigned  exp_wr [2];
  int lat [2] = '{10, 1};
  int ben [2] = '{0, 1};
  int checks = 0;
  int passed = 0;

  localparam logic [255:0] PRE = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  localparam logic [255:0] ECF = {16{16'hECFA}};
  localparam logic [255:0] KEEP = {8{32'h5A5A_0101}};

  always #5 clk = ~clk;

  data_memory_param #(.LINE_BITS(256), .DEPTH(512), .LATENCY(10), .BE_EN(0), .ADDR_BITS(32)) u_lat10 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr[0]), .data_i(din[0]), .be_i(be[0]),
    .enable_i(en[0]), .write_i(wr[0]), .ack_o(ack[0]), .data_o(dout[0]), .err_o(err[0]),
    .busy_o(busy[0]), .rd_count_o(rdc[0]), .wr_count_o(wrc[0]));

  data_memory_param #(.LINE_BITS(256), .DEPTH(512), .LATENCY(1), .BE_EN(1), .ADDR_BITS(32)) u_lat1 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr[1]), .data_i(din[1]), .be_i(be[1]),
    .enable_i(en[1]), .write_i(wr[1]), .ack_o(ack[1]), .data_o(dout[1]), .err_o(err[1]),
    .busy_o(busy[1]), .rd_count_o(rdc[1]), .wr_count_o(wrc[1]));

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] expv);
    checks++;
    assert (got === expv) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, expv);
  endtask

  task automatic push_op(input bit w, input logic [31:0] a, input logic [255:0] d, input logic [31:0] b);
    op_t o;
    o.wr = w; o.addr = a; o.dat = d; o.be = b;
    ops.push_back(o);
  endtask

  // Drives one request and pushes what the memory should answer with.
  task automatic drive(input int p, input op_t o);
    exp_t e;
    int idx;
    logic [255:0] m;
    addr[p] = o.addr; din[p] = o.dat; be[p] = o.be; wr[p] = o.wr; en[p] = 1'b1;
    idx = int'(o.addr >> 5);
    e.err = (idx >= 512);
    if (o.wr) begin
      exp_wr[p]++;
      if (!e.err) begin
        for (int k = 0; k < 32; k++) m[8*k +: 8] = {8{(ben[p] == 0) || o.be[k]}};
        mdl[p][idx] = (mdl[p][idx] & ~m) | (o.dat & m);
      end
    end else begin
      exp_rd[p]++;
      last_rd[p] = e.err ? '0 : mdl[p][idx];
    end
    e.dat = last_rd[p]; e.rdc = exp_rd[p]; e.wrc = exp_wr[p];
    sb.push_back(e);
  endtask

  // Streams all queued ops with enable held, comparing each ack against the scoreboard.
  task automatic run(input int p, output int total);
    exp_t e;
    int n;
    total = 0;
    @(negedge clk);
    drive(p, ops.pop_front());
    while (sb.size() > 0) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (n == 1) begin
          din[p] = ~din[p]; be[p] = ~be[p]; addr[p] = addr[p] ^ 32'h20; wr[p] = ~wr[p];
        end
      end while (!ack[p] && n < 400);
      total += n;
      e = sb.pop_front();
      check($sformatf("p%0d ack_latency", p), 256'(n), 256'(lat[p] + 1));
      check($sformatf("p%0d err", p), 256'(err[p]), 256'(e.err));
      check($sformatf("p%0d data", p), dout[p], e.dat);
      check($sformatf("p%0d rd_count", p), 256'(rdc[p]), 256'(e.rdc));
      check($sformatf("p%0d wr_count", p), 256'(wrc[p]), 256'(e.wrc));
      if (ops.size() > 0) drive(p, ops.pop_front());
      else en[p] = 1'b0;
    end
    @(negedge clk);
    check($sformatf("p%0d ack_single_pulse", p), 256'(ack[p]), 256'd0);
    check($sformatf("p%0d busy_after", p), 256'(busy[p]), 256'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tot;
    bit saw_ack;
    for (int p = 0; p < 2; p++) begin
      addr[p] = '0; din[p] = '0; be[p] = '0; en[p] = 1'b0; wr[p] = 1'b0;
      last_rd[p] = '0; exp_rd[p] = 0; exp_wr[p] = 0;
    end
    repeat (3) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      check("reset ack", 256'(ack[p]), 256'd0);
      check("reset err", 256'(err[p]), 256'd0);
      check("reset busy", 256'(busy[p]), 256'd0);
      check("reset data", dout[p], 256'd0);
      check("reset rd_count", 256'(rdc[p]), 256'd0);
      check("reset wr_count", 256'(wrc[p]), 256'd0);
    end
    rst = 1'b0;

    // Preload line 0, then read it back
    push_op(1'b1, 32'h0, PRE, '1);
    push_op(1'b0, 32'h0, '0, '1);
    run(0, tot);

    // Write/read back-to-back with enable held
    push_op(1'b1, 32'h40, ECF, '1);
    push_op(1'b0, 32'h40, '0, '1);
    run(0, tot);
    check("t2 total_cycles", 256'(tot), 256'd22);

    // Out-of-range line 512: write dropped, read zero, line 0 untouched
    push_op(1'b1, 32'h0000_4000, {8{32'hDEAD_BEEF}}, '1);
    push_op(1'b0, 32'h0000_4000, '0, '1);
    push_op(1'b0, 32'h0, '0, '1);
    run(0, tot);
    check("t4 line0 intact", dout[0], PRE);

    // Reset in the middle of a write to line 1
    push_op(1'b1, 32'h20, KEEP, '1);
    run(0, tot);
    @(negedge clk);
    addr[0] = 32'h20; din[0] = ~KEEP; wr[0] = 1'b1; en[0] = 1'b1;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    en[0] = 1'b0;
    check("t5 busy in reset", 256'(busy[0]), 256'd0);
    check("t5 ack in reset", 256'(ack[0]), 256'd0);
    check("t5 rd_count zeroed", 256'(rdc[0]), 256'd0);
    check("t5 wr_count zeroed", 256'(wrc[0]), 256'd0);
    check("t5 data zeroed", dout[0], 256'd0);
    for (int p = 0; p < 2; p++) begin
      exp_rd[p] = 0; exp_wr[p] = 0; last_rd[p] = '0;
    end
    @(negedge clk);
    rst = 1'b0;
    saw_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ack[0]) saw_ack = 1'b1;
    end
    check("t5 no ack after abort", 256'(saw_ack), 256'd0);
    push_op(1'b0, 32'h20, '0, '1);
    run(0, tot);
    check("t5 line1 unchanged", dout[0], KEEP);

    // Byte-enable merge on line 16, then a be=0 no-op write
    push_op(1'b1, 32'h200, '0, '1);
    push_op(1'b1, 32'h200, '1, 32'h0000_000F);
    push_op(1'b0, 32'h200, '0, '0);
    push_op(1'b1, 32'h200, {8{32'h1234_5678}}, 32'h0);
    push_op(1'b0, 32'h200, '0, '0);
    run(1, tot);
    check("t3 low four bytes", dout[1], 256'hFFFF_FFFF);

    // Three held reads at LATENCY=1; offset bits must not matter
    check("t6 busy before", 256'(busy[1]), 256'd0);
    push_op(1'b0, 32'h200, '0, '0);
    push_op(1'b0, 32'h21F, '0, '0);
    push_op(1'b0, 32'h204, '0, '0);
    run(1, tot);
    check("t6 total_cycles", 256'(tot), 256'd6);
    check("t6 data", dout[1], 256'hFFFF_FFFF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
